// File: rtl/systolic_seq_ctrl.sv
// Sequencer for the 5x5 systolic pixel-capture array: streams N_PIX pixels onto the
// broadcast bus, then walks the window-select through all taps toward the MAC.
module systolic_seq_ctrl #(
  parameter int W     = 8,
  parameter int N_PIX = 160,
  parameter int TAPS  = 25
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  output logic [7:0]   mem_addr,
  output logic         mem_rd,
  input  logic [W-1:0] mem_rdata,
  output logic [7:0]   counter_val,
  output logic [W-1:0] indata,
  output logic [4:0]   select,
  output logic         tap_valid,
  input  logic         tap_ready,
  output logic         tap_last,
  output logic         busy,
  output logic         done
);

  localparam logic [7:0] LAST_PIX = 8'(N_PIX - 1);
  localparam logic [4:0] LAST_TAP = 5'(TAPS - 1);

  typedef enum logic [2:0] {IDLE, LOAD, FLUSH, READ, DONE} state_t;

  state_t       state_reg, state_next;
  logic [7:0]   addr_reg, addr_next;
  logic         rd_reg, rd_next;
  logic         flush_reg, flush_next;
  logic [4:0]   sel_reg, sel_next;
  logic         valid_reg, valid_next;
  logic         last_reg, last_next;
  logic         busy_reg, busy_next;
  logic         done_reg, done_next;

  // Broadcast pipeline: address/enable delayed one cycle to line up with mem_rdata.
  logic         rd_d1_reg;
  logic [7:0]   addr_d1_reg;
  logic [7:0]   cv_reg;
  logic [W-1:0] indata_reg;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg <= IDLE;
      addr_reg  <= '0;
      rd_reg    <= 1'b0;
      flush_reg <= 1'b0;
      sel_reg   <= '0;
      valid_reg <= 1'b0;
      last_reg  <= 1'b0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      addr_reg  <= addr_next;
      rd_reg    <= rd_next;
      flush_reg <= flush_next;
      sel_reg   <= sel_next;
      valid_reg <= valid_next;
      last_reg  <= last_next;
      busy_reg  <= busy_next;
      done_reg  <= done_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    addr_next  = addr_reg;
    rd_next    = rd_reg;
    flush_next = flush_reg;
    sel_next   = sel_reg;
    valid_next = valid_reg;
    last_next  = last_reg;
    busy_next  = busy_reg;
    done_next  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) begin
          state_next = LOAD;
          addr_next  = '0;
          rd_next    = 1'b1;
          busy_next  = 1'b1;
        end
      end
      LOAD: begin
        if (addr_reg == LAST_PIX) begin
          state_next = FLUSH;
          rd_next    = 1'b0;
        end else begin
          addr_next = addr_reg + 8'd1;
        end
      end
      FLUSH: begin
        // Two cycles let the final read drain through the broadcast pipeline.
        if (flush_reg) begin
          state_next = READ;
          flush_next = 1'b0;
          sel_next   = '0;
          valid_next = 1'b1;
          last_next  = (LAST_TAP == 5'd0);
        end else begin
          flush_next = 1'b1;
        end
      end
      READ: begin
        if (tap_ready) begin
          if (sel_reg == LAST_TAP) begin
            state_next = DONE;
            valid_next = 1'b0;
            last_next  = 1'b0;
            done_next  = 1'b1;
          end else begin
            sel_next  = sel_reg + 5'd1;
            last_next = ((sel_reg + 5'd1) == LAST_TAP);
          end
        end
      end
      DONE: begin
        state_next = IDLE;
        sel_next   = '0;
        busy_next  = 1'b0;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_d1_reg   <= 1'b0;
      addr_d1_reg <= '0;
      cv_reg      <= 8'hFF;
      indata_reg  <= '0;
    end else begin
      rd_d1_reg   <= rd_reg;
      addr_d1_reg <= addr_reg;
      if (rd_d1_reg) begin
        cv_reg     <= addr_d1_reg;
        indata_reg <= mem_rdata;
      end else begin
        cv_reg     <= 8'hFF;
        indata_reg <= '0;
      end
    end
  end

  assign mem_addr    = addr_reg;
  assign mem_rd      = rd_reg;
  assign counter_val = cv_reg;
  assign indata      = indata_reg;
  assign select      = sel_reg;
  assign tap_valid   = valid_reg;
  assign tap_last    = last_reg;
  assign busy        = busy_reg;
  assign done        = done_reg;

endmodule
